// File: rtl/jk_counter_sequencer.sv
// Programmable up/down step counter built from WIDTH JK stages.
// A small FSM picks the per-stage J/K mode (hold, load, up or down) and sequences START/STEPS runs.
module jk_counter_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOAD_VAL,
   input  logic             START,
   input  logic             DIR,
   input  logic [WIDTH-1:0] STEPS,
   input  logic             ABORT,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   output logic             BUSY,
   output logic             DONE,
   output logic             TC
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [1:0] {M_HOLD, M_LOAD, M_UP, M_DOWN} mode_t;

   state_t           r_state, w_state_nxt;
   mode_t            w_mode;
   logic             r_dir, w_dir_nxt;
   logic [WIDTH-1:0] r_q, w_q_nxt;
   logic [WIDTH-1:0] r_rem, w_rem_nxt;
   logic [WIDTH-1:0] w_up, w_dn;

   // Toggle-enable chains: stage i flips when every lower stage is 1 (up) or 0 (down).
   always_comb begin
      w_up    = '0;
      w_dn    = '0;
      w_up[0] = 1'b1;
      w_dn[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         w_up[i] = w_up[i-1] & r_q[i-1];
         w_dn[i] = w_dn[i-1] & ~r_q[i-1];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mode      = M_HOLD;
      w_dir_nxt   = r_dir;
      w_rem_nxt   = r_rem;
      case (r_state)
         S_IDLE: begin
            if (LOAD) begin
               w_mode = M_LOAD;
            end else if (START) begin
               if (STEPS != '0) begin
                  w_dir_nxt   = DIR;
                  w_rem_nxt   = STEPS;
                  w_state_nxt = S_RUN;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (ABORT) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_mode    = r_dir ? M_UP : M_DOWN;
               w_rem_nxt = r_rem - WIDTH'(1);
               if (r_rem == WIDTH'(1)) w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      J = '0;
      K = '0;
      case (w_mode)
         M_LOAD: begin
            J = LOAD_VAL;
            K = ~LOAD_VAL;
         end
         M_UP: begin
            J = w_up;
            K = w_up;
         end
         M_DOWN: begin
            J = w_dn;
            K = w_dn;
         end
         default: begin
            J = '0;
            K = '0;
         end
      endcase
   end

   // Per-stage JK characteristic: 00 hold, 01 clear, 10 set, 11 toggle.
   always_comb begin
      w_q_nxt = r_q;
      for (int i = 0; i < WIDTH; i++) begin
         case ({J[i], K[i]})
            2'b01:   w_q_nxt[i] = 1'b0;
            2'b10:   w_q_nxt[i] = 1'b1;
            2'b11:   w_q_nxt[i] = ~r_q[i];
            default: w_q_nxt[i] = r_q[i];
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_dir   <= 1'b0;
         r_rem   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_dir   <= w_dir_nxt;
         r_rem   <= w_rem_nxt;
      end
   end

   assign Q    = r_q;
   assign BUSY = (r_state == S_RUN);
   assign DONE = (r_state == S_DONE);
   assign TC   = BUSY & (r_dir ? (&r_q) : ~(|r_q));

endmodule

// File: tb/tb_jk_counter_sequencer.sv
// Self-checking bench for jk_counter_sequencer: directed scenarios plus a randomized run
// checked against an arithmetic reference model (modulo counter, step budget, phase tracker).
module tb_jk_counter_sequencer;
   localparam int W    = 4;
   localparam int MASK = (1 << W) - 1;

   logic         CLK, RST_N, LOAD, START, DIR, ABORT;
   logic [W-1:0] LOAD_VAL, STEPS;
   logic [W-1:0] Q, J, K;
   logic         BUSY, DONE, TC;

   int total = 0;
   int bad   = 0;

   // reference model: phase 0=idle, 1=running, 2=completion cycle
   int m_q, m_ph, m_dir, m_left;

   jk_counter_sequencer #(.WIDTH(W)) dut (
      .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .START(START),
      .DIR(DIR), .STEPS(STEPS), .ABORT(ABORT), .Q(Q), .J(J), .K(K),
      .BUSY(BUSY), .DONE(DONE), .TC(TC)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic mreset();
      m_q = 0; m_ph = 0; m_dir = 0; m_left = 0;
   endtask

   task automatic model_edge();
      case (m_ph)
         0: begin
            if (LOAD) m_q = int'(LOAD_VAL);
            else if (START) begin
               if (STEPS != 0) begin
                  m_dir = int'(DIR); m_left = int'(STEPS); m_ph = 1;
               end else m_ph = 2;
            end
         end
         1: begin
            if (ABORT) m_ph = 0;
            else begin
               m_q    = m_dir ? ((m_q + 1) & MASK) : ((m_q - 1) & MASK);
               m_left = m_left - 1;
               if (m_left == 0) m_ph = 2;
            end
         end
         default: m_ph = 0;
      endcase
   endtask

   // J/K that the stages should see: the bits that change under this cycle's operation.
   task automatic model_jk(output logic [W-1:0] ej, output logic [W-1:0] ek);
      int t;
      ej = '0; ek = '0;
      if (m_ph == 0 && LOAD) begin
         ej = LOAD_VAL; ek = ~LOAD_VAL;
      end else if (m_ph == 1 && !ABORT) begin
         t  = m_dir ? (m_q ^ (m_q + 1)) : (m_q ^ (m_q - 1));
         ej = W'(t & MASK); ek = W'(t & MASK);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      LOAD = 0; START = 0; ABORT = 0; DIR = 0; LOAD_VAL = '0; STEPS = '0;
   endtask

   task automatic do_load(input logic [W-1:0] v);
      LOAD = 1; LOAD_VAL = v;
      tick();
      LOAD = 0;
   endtask

   task automatic test_reset();
      RST_N = 0; idle_inputs(); mreset();
      #3;
      total++; if (Q !== 4'h0 || BUSY !== 1'b0 || DONE !== 1'b0 || TC !== 1'b0) begin
         bad++; $display("FAIL reset_state got q=%h busy=%b done=%b tc=%b exp q=0 busy=0 done=0 tc=0", Q, BUSY, DONE, TC); end
      #9 RST_N = 1;
      do_load(4'h9);
      total++; if (Q !== 4'h9) begin bad++; $display("FAIL reset_preload got=%h exp=9", Q); end
      #2 RST_N = 0;
      #1;
      mreset();
      total++; if (Q !== 4'h0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
         bad++; $display("FAIL async_reset got q=%h busy=%b done=%b exp q=0 busy=0 done=0", Q, BUSY, DONE); end
      #1 RST_N = 1;
      tick(); tick();
      total++; if (Q !== 4'h0) begin bad++; $display("FAIL reset_release_hold got=%h exp=0", Q); end
   endtask

   task automatic test_count_up();
      logic [W-1:0] e;
      do_load(4'hA);
      total++; if (Q !== 4'hA) begin bad++; $display("FAIL up_load got=%h exp=a", Q); end
      START = 1; DIR = 1; STEPS = 4'd3;
      tick();
      START = 0; DIR = 0; STEPS = 4'd9;
      total++; if (BUSY !== 1'b1 || Q !== 4'hA) begin bad++; $display("FAIL up_start got busy=%b q=%h exp busy=1 q=a", BUSY, Q); end
      for (int k = 1; k <= 3; k++) begin
         tick();
         e = W'((10 + k) & MASK);
         total++; if (Q !== e) begin bad++; $display("FAIL up_step%0d got=%h exp=%h", k, Q, e); end
         total++; if (BUSY !== (k < 3) || DONE !== (k == 3)) begin
            bad++; $display("FAIL up_flags%0d got busy=%b done=%b exp busy=%b done=%b", k, BUSY, DONE, k < 3, k == 3); end
      end
      tick();
      total++; if (Q !== 4'hD || DONE !== 1'b0 || BUSY !== 1'b0) begin
         bad++; $display("FAIL up_after got q=%h done=%b busy=%b exp q=d done=0 busy=0", Q, DONE, BUSY); end
   endtask

   task automatic test_up_wrap();
      logic [W-1:0] e;
      do_load(4'hE);
      START = 1; DIR = 1; STEPS = 4'd3;
      tick();
      START = 0;
      total++; if (TC !== 1'b0) begin bad++; $display("FAIL upwrap_tc0 got=%b exp=0", TC); end
      for (int k = 1; k <= 3; k++) begin
         tick();
         e = W'((14 + k) & MASK);
         total++; if (Q !== e || TC !== (e == 4'hF)) begin
            bad++; $display("FAIL upwrap_step%0d got q=%h tc=%b exp q=%h tc=%b", k, Q, TC, e, e == 4'hF); end
      end
      tick();
   endtask

   task automatic test_down_wrap();
      do_load(4'h1);
      START = 1; DIR = 0; STEPS = 4'd2;
      tick();
      START = 0; DIR = 1;
      tick();
      total++; if (Q !== 4'h0 || TC !== 1'b1) begin bad++; $display("FAIL dnwrap_zero got q=%h tc=%b exp q=0 tc=1", Q, TC); end
      total++; if (J !== 4'hF || K !== 4'hF) begin bad++; $display("FAIL dnwrap_jk got j=%h k=%h exp j=f k=f", J, K); end
      tick();
      total++; if (Q !== 4'hF || TC !== 1'b0 || DONE !== 1'b1) begin
         bad++; $display("FAIL dnwrap_wrap got q=%h tc=%b done=%b exp q=f tc=0 done=1", Q, TC, DONE); end
      tick();
   endtask

   task automatic test_abort();
      do_load(4'h0);
      START = 1; DIR = 1; STEPS = 4'd8;
      tick();
      START = 0;
      tick(); tick();
      total++; if (Q !== 4'h2) begin bad++; $display("FAIL abort_pre got=%h exp=2", Q); end
      ABORT = 1;
      #1;
      total++; if (J !== 4'h0 || K !== 4'h0) begin bad++; $display("FAIL abort_jk got j=%h k=%h exp 0/0", J, K); end
      tick();
      ABORT = 0;
      total++; if (Q !== 4'h2 || BUSY !== 1'b0 || DONE !== 1'b0) begin
         bad++; $display("FAIL abort_idle got q=%h busy=%b done=%b exp q=2 busy=0 done=0", Q, BUSY, DONE); end
      for (int k = 0; k < 10; k++) begin
         tick();
         total++; if (DONE !== 1'b0) begin bad++; $display("FAIL abort_nodone%0d got=%b exp=0", k, DONE); end
      end
      do_load(4'h0);
      START = 1; DIR = 1; STEPS = 4'd8;
      tick();
      START = 0;
      for (int k = 0; k < 5; k++) tick();
      total++; if (Q !== 4'h5 || BUSY !== 1'b1) begin bad++; $display("FAIL midreset_pre got q=%h busy=%b exp q=5 busy=1", Q, BUSY); end
      #2 RST_N = 0;
      #1;
      mreset();
      total++; if (Q !== 4'h0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
         bad++; $display("FAIL midreset got q=%h busy=%b done=%b exp q=0 busy=0 done=0", Q, BUSY, DONE); end
      #1 RST_N = 1;
      tick();
      total++; if (Q !== 4'h0 || BUSY !== 1'b0) begin bad++; $display("FAIL midreset_after got q=%h busy=%b exp q=0 busy=0", Q, BUSY); end
   endtask

   task automatic test_edge_cmds();
      LOAD = 1; LOAD_VAL = 4'h6; START = 1; DIR = 1; STEPS = 4'd3;
      tick();
      LOAD = 0; START = 0;
      total++; if (Q !== 4'h6 || BUSY !== 1'b0) begin bad++; $display("FAIL load_start got q=%h busy=%b exp q=6 busy=0", Q, BUSY); end
      tick();
      total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL load_start_nobusy got=%b exp=0", BUSY); end
      START = 1; STEPS = 4'd0;
      tick();
      STEPS = 4'd5;
      total++; if (DONE !== 1'b1 || BUSY !== 1'b0 || Q !== 4'h6) begin
         bad++; $display("FAIL zero_steps got done=%b busy=%b q=%h exp done=1 busy=0 q=6", DONE, BUSY, Q); end
      tick();
      START = 0;
      total++; if (DONE !== 1'b0 || BUSY !== 1'b0 || Q !== 4'h6) begin
         bad++; $display("FAIL start_in_done got done=%b busy=%b q=%h exp done=0 busy=0 q=6", DONE, BUSY, Q); end
      tick();
      total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL start_in_done_after got=%b exp=0", BUSY); end
   endtask

   task automatic test_random();
      logic [W-1:0] ej, ek;
      logic         etc;
      for (int n = 0; n < 600; n++) begin
         LOAD     = ($urandom_range(0, 7) == 0);
         START    = ($urandom_range(0, 3) == 0);
         ABORT    = ($urandom_range(0, 15) == 0);
         DIR      = 1'($urandom_range(0, 1));
         LOAD_VAL = W'($urandom);
         STEPS    = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 4));
         if ($urandom_range(0, 99) == 0) begin
            RST_N = 0;
            #1;
            mreset();
            total++; if (Q !== '0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
               bad++; $display("FAIL rnd_reset%0d got q=%h busy=%b done=%b exp 0", n, Q, BUSY, DONE); end
            RST_N = 1;
         end
         #1;
         model_jk(ej, ek);
         total++; if (J !== ej || K !== ek) begin
            bad++; $display("FAIL rnd_jk%0d got j=%h k=%h exp j=%h k=%h", n, J, K, ej, ek); end
         tick();
         etc = (m_ph == 1) && (m_dir ? (m_q == MASK) : (m_q == 0));
         total++; if (Q !== W'(m_q) || BUSY !== (m_ph == 1) || DONE !== (m_ph == 2) || TC !== etc) begin
            bad++; $display("FAIL rnd_out%0d got q=%h busy=%b done=%b tc=%b exp q=%h busy=%b done=%b tc=%b",
                            n, Q, BUSY, DONE, TC, W'(m_q), m_ph == 1, m_ph == 2, etc); end
      end
      idle_inputs();
      for (int k = 0; k < 20; k++) tick();
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_up_wrap();
      test_down_wrap();
      test_abort();
      test_edge_cmds();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jk_counter_sequencer.md
Name: jk_counter_sequencer

Overview:
Sequencer that drives a bank of WIDTH JK flip-flop stages as a programmable up/down step counter. It computes each stage's J/K inputs from its mode: hold, load, count up or count down. It accepts a START/STEPS command, runs exactly STEPS count cycles, then reports completion with a one-cycle DONE pulse. It is the control layer used wherever the team needs a JK-built counter with load, direction and run-length control.

Parameters:
WIDTH, 4, number of JK stages (counter width); legal range 2..16.

Ports:
CLK  input  1  system clock; all state changes on its rising edge.
RST_N  input  1  asynchronous, active-low reset.
LOAD  input  1  load LOAD_VAL into the stages; honoured only in IDLE.
LOAD_VAL  input  WIDTH  value to load.
START  input  1  begin a run; honoured only in IDLE.
DIR  input  1  direction, sampled with START: 1 = up, 0 = down.
STEPS  input  WIDTH  number of count steps, sampled with START.
ABORT  input  1  terminate the run early; honoured only in RUN.
Q  output  WIDTH  stage outputs (the counter value).
J  output  WIDTH  J inputs currently applied to the stages.
K  output  WIDTH  K inputs currently applied to the stages.
BUSY  output  1  high while in RUN.
DONE  output  1  one-cycle completion pulse.
TC  output  1  terminal count: BUSY and (dir_r ? Q all ones : Q all zeros).

Behaviour:
- Reset (RST_N low, asynchronous, any state or mid-run): Q=0, state=IDLE, dir_r=0, remaining=0, BUSY=0, DONE=0, TC=0.
- J/K are combinational from the state and inputs:
  - Hold: J=K=0.
  - Load: J[i]=LOAD_VAL[i], K[i]=~LOAD_VAL[i].
  - Up: J[i]=K[i]=AND of Q[i-1:0]; stage 0 always toggles (J[0]=K[0]=1).
  - Down: J[i]=K[i]=AND of ~Q[i-1:0]; J[0]=K[0]=1.
- Each stage updates per JK rules on every CLK edge: 00 hold, 01 clear, 10 set, 11 toggle. Qbar is not exported.
- Counting is modulo 2^WIDTH; wrap-around (F->0 up, 0->F down) is normal behaviour, not an error.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - LOAD=1: apply load; next state IDLE.
  - else START=1 and STEPS!=0: hold this cycle; capture dir_r=DIR and remaining=STEPS; next state RUN.
  - else START=1 and STEPS=0: hold; next state DONE.
  - else: hold.
  - LOAD and START together: LOAD wins; START is dropped and no run begins.
- RUN, BUSY=1:
  - ABORT=1: hold (no step this cycle); next state IDLE; no DONE pulse.
  - else: apply the up or down step per dir_r; remaining decrements.
  - When remaining=1 on that edge, next state is DONE; otherwise stay in RUN.
  - LOAD and START are ignored.
- DONE: DONE=1 for exactly one cycle; hold; next state IDLE unconditionally; START and LOAD are ignored.
- Timing: START sampled at edge 0 gives count steps at edges 1..STEPS. BUSY is high from edge 0 to edge STEPS. DONE is high in the cycle after edge STEPS. The earliest next START is accepted at edge STEPS+2.
- DIR and STEPS changes during RUN have no effect.
- TC is combinational and is 0 outside RUN.

Test Plan:
1. Async reset: drive Q to 0x9, then pull RST_N low between clock edges -> Q=0, BUSY=0, DONE=0 immediately without a clock; release, no LOAD -> Q stays 0.
2. Load and count up (WIDTH=4): LOAD 0xA, then START DIR=1 STEPS=3 -> Q=0xB, 0xC, 0xD at edges 1..3; BUSY high for 3 cycles; DONE high for 1 cycle after edge 3; Q then holds 0xD.
3. Up wrap: load 0xE, START DIR=1 STEPS=3 -> Q=0xF, 0x0, 0x1; TC=1 only in the cycle Q=0xF.
4. Down wrap: load 0x1, START DIR=0 STEPS=2 -> Q=0x0, 0xF; TC=1 only in the cycle Q=0x0; J/K in that cycle = 0xF/0xF.
5. Abort and reset mid-run:
   - From Q=0, START up STEPS=8; assert ABORT in the cycle Q=2 -> Q stays 2, IDLE next cycle, DONE never pulses.
   - Repeat with RST_N low at Q=5 -> Q=0, IDLE.
6. Edge commands:
   - LOAD=1 with LOAD_VAL=0x6 and START=1 in the same cycle -> Q=0x6, BUSY stays 0.
   - Then START STEPS=0 -> DONE pulses the next cycle, Q unchanged at 0x6, BUSY never asserts.
   - START asserted during DONE -> ignored.
